// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared datapath types
package core_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0] word;

endpackage

// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - decoder-facing enums: writeback mux select and M-extension ops
package decoder_pkg;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_PC4 = 2'd2,
    WB_MUL = 2'd3
  } wb_mux_t;

  // Encoding matches funct3 of the RV32M instructions (funct7 = 0000001).
  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } mul_op_t;

  function automatic logic op_is_div(mul_op_t o);
    return o[2];
  endfunction

  function automatic logic op_signed_a(mul_op_t o);
    return (o == MD_MULH) || (o == MD_MULHSU) || (o == MD_DIV) || (o == MD_REM);
  endfunction

  function automatic logic op_signed_b(mul_op_t o);
    return (o == MD_MULH) || (o == MD_DIV) || (o == MD_REM);
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide, fixed 33-cycle latency
import core_pkg::*;
import decoder_pkg::*;

module mul_div_unit (
  input  logic    clk,
  input  logic    reset,
  input  logic    start,
  input  mul_op_t op,
  input  word     a,
  input  word     b,
  output logic    busy,
  output logic    valid,
  output word     result
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  word         opnd_q, opnd_d;
  mul_op_t     op_q, op_d;
  logic        neg_q, neg_d;
  logic        neg_rem_q, neg_rem_d;
  logic        dz_q, dz_d;
  logic        ovf_q, ovf_d;
  logic        valid_q, valid_d;
  word         result_q, result_d;

  logic        a_sgn, b_sgn;
  word         a_mag, b_mag;
  logic [32:0] add_x, add_y;
  logic [33:0] add_s;
  logic        div_mode;
  logic [63:0] prod;
  word         quo, remv, fix_res;

  always_comb begin
    a_sgn = op_signed_a(op) & a[31];
    b_sgn = op_signed_b(op) & b[31];
    a_mag = a_sgn ? (32'd0 - a) : a;
    b_mag = b_sgn ? (32'd0 - b) : b;

    // One 33-bit adder: multiplicand add for MUL*, trial subtract of the divisor for DIV*.
    div_mode = op_is_div(op_q);
    add_x    = div_mode ? acc_q[63:31] : {1'b0, acc_q[63:32]};
    add_y    = div_mode ? ~{1'b0, opnd_q} : {1'b0, opnd_q};
    add_s    = {1'b0, add_x} + {1'b0, add_y} + {33'd0, div_mode};

    prod = neg_q ? (64'd0 - acc_q) : acc_q;
    quo  = neg_q ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
    remv = neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];

    case (op_q)
      MD_MUL:                       fix_res = prod[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fix_res = prod[63:32];
      MD_DIV, MD_DIVU:              fix_res = dz_q ? 32'hFFFF_FFFF : (ovf_q ? 32'h8000_0000 : quo);
      MD_REM, MD_REMU:              fix_res = ovf_q ? 32'd0 : remv;
      default:                      fix_res = 32'd0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    dz_d      = dz_q;
    ovf_d     = ovf_q;
    valid_d   = 1'b0;
    result_d  = result_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d      = op;
          neg_d     = a_sgn ^ b_sgn;
          neg_rem_d = a_sgn;
          dz_d      = (b == 32'd0);
          ovf_d     = ((op == MD_DIV) || (op == MD_REM)) &&
                      (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
          acc_d     = {32'd0, op_is_div(op) ? a_mag : b_mag};
          opnd_d    = op_is_div(op) ? b_mag : a_mag;
          cnt_d     = 5'd0;
          state_d   = S_CALC;
        end
      end
      S_CALC: begin
        // add_s[33] is the no-borrow flag of the trial subtraction.
        if (div_mode) begin
          if (add_s[33]) acc_d = {add_s[31:0], acc_q[30:0], 1'b1};
          else           acc_d = {acc_q[62:0], 1'b0};
        end else begin
          if (acc_q[0]) acc_d = {add_s[32:0], acc_q[31:1]};
          else          acc_d = {1'b0, acc_q[63:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = fix_res;
        valid_d  = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= 5'd0;
      acc_q     <= 64'd0;
      opnd_q    <= 32'd0;
      op_q      <= MD_MUL;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      dz_q      <= 1'b0;
      ovf_q     <= 1'b0;
      valid_q   <= 1'b0;
      result_q  <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      dz_q      <= dz_d;
      ovf_q     <= ovf_d;
      valid_q   <= valid_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign valid  = valid_q;
  assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - self-checking bench for mul_div_unit against an arithmetic reference
module tb_mul_div_unit;
  import core_pkg::*;
  import decoder_pkg::*;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  logic    start = 1'b0;
  mul_op_t op = MD_MUL;
  word     a = 32'd0;
  word     b = 32'd0;
  logic    busy;
  logic    valid;
  word     result;

  mul_div_unit dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int issue_cyc = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic word ref_result(mul_op_t o, word x, word y);
    int          sx, sy;
    longint      lx, ly, uy;
    logic [63:0] p;
    sx = x;
    sy = y;
    lx = sx;
    ly = sy;
    uy = {32'd0, y};
    case (o)
      MD_MUL:    begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
      MD_MULH:   begin p = lx * ly; return p[63:32]; end
      MD_MULHSU: begin p = lx * uy; return p[63:32]; end
      MD_MULHU:  begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      MD_DIV: begin
        if (y == 32'd0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        return sx / sy;
      end
      MD_REM: begin
        if (y == 32'd0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        return sx % sy;
      end
      MD_DIVU: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
      default: return (y == 32'd0) ? x : x % y;
    endcase
  endfunction

  // Reference timing: a countdown of the fixed latency, result published when it expires.
  int   m_rem = 0;
  logic m_valid = 1'b0;
  word  m_result = 32'd0;
  word  m_pending = 32'd0;
  bit   cmp_en = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) begin
      m_rem    <= 0;
      m_valid  <= 1'b0;
      m_result <= 32'd0;
    end else begin
      m_valid <= 1'b0;
      if (m_rem > 0) begin
        m_rem <= m_rem - 1;
        if (m_rem == 1) begin
          m_valid  <= 1'b1;
          m_result <= m_pending;
        end
      end else if (start) begin
        m_rem     <= 33;
        m_pending <= ref_result(op, a, b);
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_busy", {31'd0, busy}, {31'd0, (m_rem != 0)});
      chk("cyc_valid", {31'd0, valid}, {31'd0, m_valid});
      chk("cyc_result", result, m_result);
    end
  end

  task automatic issue(mul_op_t o, word x, word y);
    start = 1'b1;
    op    = o;
    a     = x;
    b     = y;
    @(negedge clk);
    issue_cyc = cyc;
    start = 1'b0;
  endtask

  task automatic wait_valid(string name);
    while (!valid && (cyc - issue_cyc) < 60) @(negedge clk);
    if (!valid) chk({name, "_timeout"}, 32'd0, 32'd1);
    else        chk({name, "_latency"}, cyc - issue_cyc, 32'd33);
  endtask

  task automatic run(string name, mul_op_t o, word x, word y, word exp);
    chk({name, "_model"}, ref_result(o, x, y), exp);
    issue(o, x, y);
    wait_valid(name);
    chk(name, result, exp);
  endtask

  function automatic word pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit saw;
    mul_op_t ro;
    word ra, rb;

    repeat (3) @(negedge clk);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_valid", {31'd0, valid}, 32'd0);
    chk("reset_result", result, 32'd0);
    reset = 1'b0;
    cmp_en = 1'b1;
    @(negedge clk);

    run("mul_7x6", MD_MUL, 32'd7, 32'd6, 32'd42);
    repeat (7) @(negedge clk);
    chk("mul_hold_c40", result, 32'd42);

    run("mulh_min", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    run("mulhu_max", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run("mulhsu_m1", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run("mul_wrap", MD_MUL, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD);
    run("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    run("rem_m7_2", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    run("divu_7_2", MD_DIVU, 32'd7, 32'd2, 32'd3);
    run("remu_7_2", MD_REMU, 32'd7, 32'd2, 32'd1);
    run("divu_big", MD_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);
    run("div_by0", MD_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF);
    run("remu_by0", MD_REMU, 32'd5, 32'd0, 32'd5);
    run("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    run("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0);
    @(negedge clk);

    // start while busy is ignored
    issue(MD_MUL, 32'd7, 32'd6);
    repeat (4) @(negedge clk);
    start = 1'b1; op = MD_MUL; a = 32'd2; b = 32'd2;
    @(negedge clk);
    start = 1'b0;
    wait_valid("busy_ignore");
    chk("busy_ignore", result, 32'd42);
    // back-to-back start in the valid cycle
    run("b2b_3x3", MD_MUL, 32'd3, 32'd3, 32'd9);
    @(negedge clk);

    // reset mid-divide discards the operation
    issue(MD_DIV, 32'd100, 32'd7);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_valid", {31'd0, valid}, 32'd0);
    chk("rst_result", result, 32'd0);
    saw = 1'b0;
    repeat (45) begin
      @(negedge clk);
      if (valid) saw = 1'b1;
    end
    chk("rst_no_valid", {31'd0, saw}, 32'd0);
    run("mul_2x3", MD_MUL, 32'd2, 32'd3, 32'd6);
    @(negedge clk);

    for (int i = 0; i < 150; i++) begin
      ro = mul_op_t'($urandom_range(0, 7));
      ra = pick_operand();
      rb = pick_operand();
      issue(ro, ra, rb);
      wait_valid("rand");
      chk("rand_result", result, ref_result(ro, ra, rb));
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
